// File: rtl/test_pattern_gen_pkg.sv
// Shared definitions for the video test pattern generator: pattern mode
// encodings and the channel positions of the packed {b,g,r} colour word.
package test_pattern_gen_pkg;

    typedef enum logic [1:0] {
        MODE_GRID   = 2'd0,
        MODE_BARS   = 2'd1,
        MODE_CHECK  = 2'd2,
        MODE_SCROLL = 2'd3
    } mode_e;

    localparam int BGR_R = 0;
    localparam int BGR_G = 1;
    localparam int BGR_B = 2;

endpackage

// File: rtl/test_pattern_gen_frame_ctrl.sv
// Frame-level control: vsync edge detect, frame-boundary mode latch,
// animation frame counter and the scroll offset derived from it.
module pattern_frame_ctrl
    import test_pattern_gen_pkg::*;
#(
    parameter int H_BITS       = 9,
    parameter int FRAME_BITS   = 8,
    parameter int SCROLL_STEP  = 1,
    parameter bit VSYNC_ACTIVE = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  vsync_in,
    input  logic [1:0]            mode_sel,
    input  logic                  freeze,
    output logic [1:0]            active_mode,
    output logic [H_BITS-1:0]     offset,
    output logic                  frame_tick,
    output logic [FRAME_BITS-1:0] frame_cnt
);

    logic  vsync_prev;
    logic  frame_start;
    mode_e mode_q;

    assign frame_start = (vsync_in == VSYNC_ACTIVE) && (vsync_prev != VSYNC_ACTIVE);
    assign active_mode = mode_q;
    // Uses the counter value before this frame's increment.
    assign offset      = H_BITS'(32'(frame_cnt) * SCROLL_STEP);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vsync_prev <= ~VSYNC_ACTIVE;
            mode_q     <= MODE_GRID;
            frame_tick <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            vsync_prev <= vsync_in;
            frame_tick <= frame_start;
            if (frame_start) begin
                mode_q <= mode_e'(mode_sel);
                if (!freeze)
                    frame_cnt <= frame_cnt + FRAME_BITS'(1);
            end
        end
    end

endmodule

// File: rtl/test_pattern_gen.sv
// Multi-mode video test pattern generator placed between the sync generator
// and the RGB pins; colour and sync are registered together so they align.
module test_pattern_gen
    import test_pattern_gen_pkg::*;
#(
    parameter int H_BITS       = 9,
    parameter int V_BITS       = 9,
    parameter int COLOR_BITS   = 1,
    parameter int GRID_LOG2    = 3,
    parameter int CHECK_BIT    = 4,
    parameter int BAR_SHIFT    = 5,
    parameter int FRAME_BITS   = 8,
    parameter int SCROLL_STEP  = 1,
    parameter bit VSYNC_ACTIVE = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    hsync_in,
    input  logic                    vsync_in,
    input  logic                    display_on,
    input  logic [H_BITS-1:0]       hpos,
    input  logic [V_BITS-1:0]       vpos,
    input  logic [1:0]              mode_sel,
    input  logic                    freeze,
    output logic                    hsync,
    output logic                    vsync,
    output logic [3*COLOR_BITS-1:0] rgb,
    output logic                    frame_tick,
    output logic [FRAME_BITS-1:0]   frame_cnt
);

    if (BAR_SHIFT + 3 > H_BITS) begin : g_bad_bar_shift
        $error("test_pattern_gen: BAR_SHIFT+3 exceeds H_BITS");
    end

    // Whole-vector masks keep every position bit formally in use.
    localparam logic [H_BITS-1:0] H_GRID_MASK = H_BITS'((1 << GRID_LOG2) - 1);
    localparam logic [V_BITS-1:0] V_GRID_MASK = V_BITS'((1 << GRID_LOG2) - 1);
    localparam logic [H_BITS-1:0] H_BIT4      = H_BITS'(1 << 4);
    localparam logic [V_BITS-1:0] V_BIT4      = V_BITS'(1 << 4);
    localparam logic [H_BITS-1:0] H_CHK       = H_BITS'(1 << CHECK_BIT);
    localparam logic [V_BITS-1:0] V_CHK       = V_BITS'(1 << CHECK_BIT);

    logic [1:0]              active_mode;
    logic [H_BITS-1:0]       offset;
    logic [H_BITS-1:0]       hx;
    logic [2:0]              pix;
    logic [3*COLOR_BITS-1:0] rgb_d;
    mode_e                   mode;

    pattern_frame_ctrl #(
        .H_BITS      (H_BITS),
        .FRAME_BITS  (FRAME_BITS),
        .SCROLL_STEP (SCROLL_STEP),
        .VSYNC_ACTIVE(VSYNC_ACTIVE)
    ) u_frame_ctrl (
        .clk        (clk),
        .reset      (reset),
        .vsync_in   (vsync_in),
        .mode_sel   (mode_sel),
        .freeze     (freeze),
        .active_mode(active_mode),
        .offset     (offset),
        .frame_tick (frame_tick),
        .frame_cnt  (frame_cnt)
    );

    assign mode = mode_e'(active_mode);

    always_comb begin
        hx  = (mode == MODE_SCROLL) ? hpos + offset : hpos;
        pix = '0;
        case (mode)
            MODE_BARS:  pix = 3'(hpos >> BAR_SHIFT);
            MODE_CHECK: pix = {3{(|(hpos & H_CHK)) ^ (|(vpos & V_CHK))}};
            default: begin
                pix[BGR_R] = ((hx & H_GRID_MASK) == '0) || ((vpos & V_GRID_MASK) == '0);
                pix[BGR_G] = |(vpos & V_BIT4);
                pix[BGR_B] = |(hx & H_BIT4);
            end
        endcase
    end

    for (genvar c = 0; c < 3; c++) begin : g_chan
        assign rgb_d[c*COLOR_BITS +: COLOR_BITS] = {COLOR_BITS{pix[c] & display_on}};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hsync <= 1'b0;
            vsync <= 1'b0;
            rgb   <= '0;
        end else begin
            hsync <= hsync_in;
            vsync <= vsync_in;
            rgb   <= rgb_d;
        end
    end

endmodule

// File: tb/tb_test_pattern_gen.sv
// Directed bench: default instance plus a 2-bit frame counter instance and a
// 4-bit colour / step-2 scroll instance, all driven by the same inputs.
module tb_test_pattern_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic       hsync_in, vsync_in, display_on, freeze;
    logic [8:0] hpos, vpos;
    logic [1:0] mode_sel;

    logic        hs0, vs0, ft0, hs1, vs1, ft1, hs2, vs2, ft2;
    logic [2:0]  rgb0, rgb1;
    logic [11:0] rgb2;
    logic [7:0]  fc0, fc2;
    logic [1:0]  fc1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    test_pattern_gen u0 (
        .clk(clk), .reset(reset), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .display_on(display_on), .hpos(hpos), .vpos(vpos), .mode_sel(mode_sel),
        .freeze(freeze), .hsync(hs0), .vsync(vs0), .rgb(rgb0),
        .frame_tick(ft0), .frame_cnt(fc0)
    );

    test_pattern_gen #(.FRAME_BITS(2)) u1 (
        .clk(clk), .reset(reset), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .display_on(display_on), .hpos(hpos), .vpos(vpos), .mode_sel(mode_sel),
        .freeze(freeze), .hsync(hs1), .vsync(vs1), .rgb(rgb1),
        .frame_tick(ft1), .frame_cnt(fc1)
    );

    test_pattern_gen #(.COLOR_BITS(4), .SCROLL_STEP(2)) u2 (
        .clk(clk), .reset(reset), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .display_on(display_on), .hpos(hpos), .vpos(vpos), .mode_sel(mode_sel),
        .freeze(freeze), .hsync(hs2), .vsync(vs2), .rgb(rgb2),
        .frame_tick(ft2), .frame_cnt(fc2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame_pulse();
        vsync_in = 1'b1;
        tick();
        vsync_in = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; hsync_in = 0; vsync_in = 0; display_on = 0; freeze = 0;
        hpos = '0; vpos = '0; mode_sel = 2'd0;
        repeat (2) tick();
        chk("rst_rgb", 32'(rgb0), 0);
        chk("rst_hs", 32'(hs0), 0);
        chk("rst_vs", 32'(vs0), 0);
        chk("rst_ft", 32'(ft0), 0);
        chk("rst_fc", 32'(fc0), 0);
        reset = 1'b0;

        // Enter checker mode, check COLOR_BITS replication and sync delay
        mode_sel = 2'd2;
        frame_pulse();
        hpos = 9'd16; vpos = 9'd0; display_on = 1; hsync_in = 1;
        tick();
        chk("chk_rgb0", 32'(rgb0), 32'h7);
        chk("chk_rgb2_fff", 32'(rgb2), 32'hFFF);
        chk("hs_delay", 32'(hs0), 1);
        hpos = 9'd16; vpos = 9'd16; hsync_in = 0;
        tick();
        chk("chk_rgb2_000", 32'(rgb2), 32'h000);
        chk("hs_fall", 32'(hs0), 0);

        // Reset mid-line with checker mode active
        hpos = 9'd16; vpos = 9'd0; hsync_in = 1;
        tick();
        chk("pre_rst_rgb", 32'(rgb0), 32'h7);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_rgb", 32'(rgb0), 0);
        chk("mid_rst_hs", 32'(hs0), 0);
        chk("mid_rst_vs", 32'(vs0), 0);
        chk("mid_rst_fc", 32'(fc0), 0);
        tick();
        reset = 1'b0;
        hsync_in = 0; hpos = 9'd0; vpos = 9'd0; display_on = 1;
        tick();
        chk("post_rst_grid", 32'(rgb0), 32'h1);

        // Grid mode pixels and blanking
        hpos = 9'd16; vpos = 9'd3;
        tick();
        chk("grid_16_3", 32'(rgb0), 32'h5);
        chk("grid_16_3_c4", 32'(rgb2), 32'hF0F);
        hpos = 9'd5; vpos = 9'd5;
        tick();
        chk("grid_5_5", 32'(rgb0), 32'h0);
        hpos = 9'd0; vpos = 9'd0; display_on = 0;
        tick();
        chk("blank", 32'(rgb0), 32'h0);

        // Mode request mid-frame is held off until the vsync edge
        display_on = 1; vpos = 9'd3; hpos = 9'hA0; mode_sel = 2'd3;
        tick();
        mode_sel = 2'd1;
        tick();
        chk("mode_hold", 32'(rgb0), 32'h1);
        vsync_in = 1;
        tick();
        chk("fs_tick", 32'(ft0), 1);
        chk("fs_old_mode", 32'(rgb0), 32'h1);
        chk("fs_vs", 32'(vs0), 1);
        chk("fs_cnt", 32'(fc0), 1);
        vsync_in = 0;
        tick();
        chk("fs_tick_off", 32'(ft0), 0);
        chk("bars_idx5", 32'(rgb0), 32'h5);
        chk("vs_fall", 32'(vs0), 0);

        // Frame counting, freeze and 2-bit wrap
        do_reset();
        mode_sel = 2'd0; freeze = 0;
        repeat (3) frame_pulse();
        chk("cnt3", 32'(fc0), 3);
        chk("cnt3_w2", 32'(fc1), 3);
        freeze = 1;
        vsync_in = 1;
        tick();
        chk("frz_tick", 32'(ft0), 1);
        chk("frz_cnt", 32'(fc0), 3);
        vsync_in = 0;
        tick();
        frame_pulse();
        chk("frz_hold", 32'(fc0), 3);
        freeze = 0;
        repeat (2) frame_pulse();
        chk("cnt5", 32'(fc0), 5);
        chk("wrap_w2", 32'(fc1), 1);

        // Scroll mode after four frames
        do_reset();
        mode_sel = 2'd3;
        repeat (4) frame_pulse();
        chk("scr_cnt", 32'(fc2), 4);
        display_on = 1; hpos = 9'd8; vpos = 9'd3;
        tick();
        chk("scr_h8_s2", 32'(rgb2), 32'hF0F);
        chk("scr_h8_s1", 32'(rgb0), 32'h0);
        hpos = 9'd504;
        tick();
        chk("scr_wrap_s2", 32'(rgb2), 32'h00F);
        chk("scr_wrap_s1", 32'(rgb0), 32'h4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
